aes_eth_tx_ctrl: RTL and testbench
==================================

// Module: aes_eth_tx_ctrl
// PURPOSE
//  Sequences AES ciphertext blocks into Ethernet frames for the TSE MAC TX stream. Prepends a
//  128b MAC header (16b pad, dst MAC, src MAC, ETH_TYPE), then emits N 128b blocks as 32b words.
//  Holds the MAC address and frame-size registers behind an Avalon-MM slave at PERIPHERAL_ADDR.
//  Sits between the AES core output and the TSE Avalon-ST TX input.
// PARAMETERS
//  BASE_ADDR      PERIPHERAL_ADDR ('h1000)  Avalon-MM base; register offsets are added to it.
//  DEF_BLOCKS     1                         Reset value of BLOCKS register (blocks per frame).
// PORTS
//  clk            in   1    Single clock.
//  rst            in   1    Synchronous, active-high reset.
//  avs_address    in   32   Byte address (ADDRESS_SIZE).
//  avs_write      in   1    Write strobe.
//  avs_writedata  in   32   Write data (REG_SIZE).
//  avs_read       in   1    Read strobe.
//  avs_readdata   out  32   Read data, registered, valid 1 cycle after avs_read.
//  aes_data       in   128  Ciphertext block, [127:96] sent first.
//  aes_valid      in   1    Block valid.
//  aes_ready      out  1    Block accepted when aes_valid && aes_ready.
//  tx_data        out  32   MAC_STREAM_WIDTH word to TSE.
//  tx_valid       out  1    Word valid.
//  tx_ready       in   1    TSE accepts the word when tx_valid && tx_ready.
//  tx_sop         out  1    First header word.
//  tx_eop         out  1    Last word of last block.
//  tx_empty       out  2    Always 0 (frames are whole words).
//  busy           out  1    High from SOP issue to EOP acceptance.
// BEHAVIOUR
//  Registers (offset from BASE_ADDR): 'h0 SRC[47:32] (bits 15:0), 'h4 SRC[31:0], 'h8 DST[47:32],
//  'hC DST[31:0], 'h10 BLOCKS[7:0] (WORD_COUNTER_SIZE; 0 is treated as 1), 'h14 STATUS RO {31'b0,busy}.
//  Unmapped reads return 0. Writes to unmapped or RO registers are ignored.
//  Reset: all outputs 0, MAC registers 0, BLOCKS=DEF_BLOCKS, FSM=IDLE.
//  FSM: IDLE -> HDR (4 words) -> PAY (4*BLOCKS words) -> IDLE.
//   IDLE: aes_ready=0. aes_valid=1 latches SRC/DST/BLOCKS into shadow registers and moves to HDR.
//     tx_valid and tx_sop go high on the next cycle (1-cycle latency). No block is consumed yet.
//   HDR words: w0={16'h0,DST[47:32]}, w1=DST[31:0], w2=SRC[47:16], w3={SRC[15:0],ETH_TYPE 16'h0800}.
//   PAY: 128b holding register blk_q with a blk_full flag. Words are emitted MSB-first, word_idx 0..3.
//   aes_ready = in HDR/PAY && blocks_taken<BLOCKS && (!blk_full || (word_idx==3 && tx_valid && tx_ready)).
//     This gives same-cycle reload and no bubbles at full rate (combinational tx_ready->aes_ready path).
//   tx_valid in PAY = blk_full. When a block is late, tx_valid drops mid-frame; this is legal for TSE.
//   tx_eop is asserted on word_idx==3 of block BLOCKS. Its acceptance returns the FSM to IDLE.
//   The next frame can start on the following cycle.
//  Handshake: tx_data, tx_sop and tx_eop stay stable while tx_valid && !tx_ready.
//   An aes block taken by aes_valid && aes_ready is never dropped.
//  Config writes while busy update the live registers only. The current frame uses the shadow
//   values; the new values apply from the next SOP.
//  Simultaneous write and read of the same register: the read returns the old value.
//  blocks_taken counts 0..BLOCKS. At 255 there is no wrap, because the FSM leaves PAY first.
//  rst mid-frame: immediate return to IDLE and blk_q discarded. The TSE sees tx_valid fall without
//   eop; this abort is accepted.
// CONFIGURATION
//  AES_TX_STATS_EN defined:
//   'h18 FRAMES RO: 32b count of EOPs accepted, wraps at 2^32-1 -> 0.
//   'h1C STALLS RO: 32b count of cycles with tx_valid && !tx_ready, saturates.
//   A write of any value to 'h18 clears both counters. A clear coincident with an increment wins.
//  AES_TX_STATS_EN undefined: no counter logic is built, and 'h18/'h1C read 0.
// TESTING
//  1. Reset, write SRC=0x0011_22334455, DST=0xAABB_CCDDEEFF, BLOCKS=1, push one block 0x00..0F:
//     expect 8 words 0x0000AABB, 0xCCDDEEFF, 0x00112233, 0x44550800, 0x00010203..0x0C0D0E0F,
//     with sop on w0 and eop on w7.
//  2. BLOCKS=3, aes_valid held high, tx_ready=1: expect 16 words in 16 consecutive cycles.
//     aes_ready must pulse exactly 3 times.
//  3. tx_ready toggled 1/0 every cycle: word order and data are identical to test 2.
//     tx_data stays stable across stall cycles.
//  4. Write DST=0x1 while the header is in flight: the current frame carries the old DST.
//     The next frame carries 0x000000000001.
//  5. Assert rst at PAY word 5: the next cycle shows tx_valid=0, busy=0, aes_ready=0.
//     Registers read back at their reset values.
//  6. BLOCKS=0 behaves as 1. With AES_TX_STATS_EN, FRAMES reads 2 after two frames and 0 after a write to 'h18.

Source files
------------

// File: rtl/aes_eth_tx_ctrl_if.sv
// Bus bundle for aes_eth_tx_ctrl: Avalon-MM config slave, AES block input and TSE Avalon-ST TX output.
interface aes_eth_tx_ctrl_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned REG_W  = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [REG_W-1:0]  avs_writedata;
    logic              avs_read;
    logic [REG_W-1:0]  avs_readdata;
    logic [BLK_W-1:0]  aes_data;
    logic              aes_valid;
    logic              aes_ready;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_sop;
    logic              tx_eop;
    logic [1:0]        tx_empty;
    logic              busy;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read, aes_data, aes_valid, tx_ready,
        input  avs_readdata, aes_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_empty, busy
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read, aes_data, aes_valid, tx_ready,
        output avs_readdata, aes_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_empty, busy
    );
endinterface

// File: rtl/aes_eth_tx_ctrl.sv
// Frames AES ciphertext blocks behind a 128b MAC header onto the TSE TX stream as 32b words.
// Optional AES_TX_STATS_EN adds FRAMES/STALLS counters at offsets 'h18/'h1C.
module aes_eth_tx_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000,
    parameter int unsigned DEF_BLOCKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    aes_eth_tx_ctrl_if.slave bus
);
    localparam int unsigned REG_W  = 32;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;

    localparam logic [15:0] ETH_TYPE = 16'h0800;

    localparam logic [31:0] A_SRC_HI = BASE_ADDR + 32'h00;
    localparam logic [31:0] A_SRC_LO = BASE_ADDR + 32'h04;
    localparam logic [31:0] A_DST_HI = BASE_ADDR + 32'h08;
    localparam logic [31:0] A_DST_LO = BASE_ADDR + 32'h0C;
    localparam logic [31:0] A_BLOCKS = BASE_ADDR + 32'h10;
    localparam logic [31:0] A_STATUS = BASE_ADDR + 32'h14;
`ifdef AES_TX_STATS_EN
    localparam logic [31:0] A_FRAMES = BASE_ADDR + 32'h18;
    localparam logic [31:0] A_STALLS = BASE_ADDR + 32'h1C;
`endif

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t             state;
    logic [MAC_W-1:0]   src_q;
    logic [MAC_W-1:0]   dst_q;
    logic [CNT_W-1:0]   blocks_q;
    logic [CNT_W-1:0]   sh_blocks;
    logic [CNT_W-1:0]   blocks_taken;
    logic [BLK_W-1:0]   blk_q;
    logic               blk_full;
    logic [IDX_W-1:0]   word_idx;
    logic               tx_sop_q;
    logic               tx_eop_q;
    logic               busy_q;
    logic [REG_W-1:0]   readdata_q;
    logic [REG_W-1:0]   rd_data_c;
    logic               tx_fire_c;
    logic               aes_ready_c;
    logic               aes_take_c;

    // blk_q doubles as the header shadow, so tx_data is always its top word
    assign bus.tx_data      = blk_q[BLK_W-1 -: WORD_W];
    assign bus.tx_valid     = blk_full;
    assign bus.tx_sop       = tx_sop_q;
    assign bus.tx_eop       = tx_eop_q;
    assign bus.tx_empty     = 2'b00;
    assign bus.busy         = busy_q;
    assign bus.avs_readdata = readdata_q;
    assign bus.aes_ready    = aes_ready_c;

    assign tx_fire_c  = blk_full && bus.tx_ready;
    assign aes_take_c = aes_ready_c && bus.aes_valid;

    // Reload in the same cycle the last word of the held block leaves
    always_comb begin
        aes_ready_c = 1'b0;
        if (state != IDLE && blocks_taken < sh_blocks)
            aes_ready_c = !blk_full || (word_idx == IDX_W'(3) && tx_fire_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sh_blocks    <= CNT_W'(1);
            blocks_taken <= '0;
            blk_q        <= '0;
            blk_full     <= 1'b0;
            word_idx     <= '0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.aes_valid) begin
                        sh_blocks    <= (blocks_q == '0) ? CNT_W'(1) : blocks_q;
                        blk_q        <= {16'h0000, dst_q, src_q, ETH_TYPE};
                        blk_full     <= 1'b1;
                        tx_sop_q     <= 1'b1;
                        tx_eop_q     <= 1'b0;
                        word_idx     <= '0;
                        blocks_taken <= '0;
                        busy_q       <= 1'b1;
                        state        <= HDR;
                    end
                end
                HDR: begin
                    if (tx_fire_c) begin
                        tx_sop_q <= 1'b0;
                        word_idx <= word_idx + IDX_W'(1);
                        blk_q    <= {blk_q[BLK_W-WORD_W-1:0], WORD_W'(0)};
                        if (word_idx == IDX_W'(3)) begin
                            blk_full <= 1'b0;
                            state    <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (tx_fire_c) begin
                        word_idx <= word_idx + IDX_W'(1);
                        blk_q    <= {blk_q[BLK_W-WORD_W-1:0], WORD_W'(0)};
                        if (word_idx == IDX_W'(2) && blocks_taken == sh_blocks)
                            tx_eop_q <= 1'b1;
                        if (word_idx == IDX_W'(3)) begin
                            blk_full <= 1'b0;
                            tx_eop_q <= 1'b0;
                            if (tx_eop_q) begin
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (aes_take_c) begin
                blk_q        <= bus.aes_data;
                blk_full     <= 1'b1;
                blocks_taken <= blocks_taken + CNT_W'(1);
            end
        end
    end

`ifdef AES_TX_STATS_EN
    logic [REG_W-1:0] frames_q;
    logic [REG_W-1:0] stalls_q;
    logic             stats_clr_c;

    assign stats_clr_c = bus.avs_write && bus.avs_address == A_FRAMES;

    // Clear beats a coincident increment
    always_ff @(posedge clk) begin
        if (rst || stats_clr_c) begin
            frames_q <= '0;
            stalls_q <= '0;
        end else begin
            if (tx_fire_c && tx_eop_q)
                frames_q <= frames_q + REG_W'(1);
            if (blk_full && !bus.tx_ready && stalls_q != '1)
                stalls_q <= stalls_q + REG_W'(1);
        end
    end
`endif

    always_comb begin
        rd_data_c = '0;
        case (bus.avs_address)
            A_SRC_HI: rd_data_c = {16'h0000, src_q[47:32]};
            A_SRC_LO: rd_data_c = src_q[31:0];
            A_DST_HI: rd_data_c = {16'h0000, dst_q[47:32]};
            A_DST_LO: rd_data_c = dst_q[31:0];
            A_BLOCKS: rd_data_c = {24'h000000, blocks_q};
            A_STATUS: rd_data_c = {31'h0, busy_q};
`ifdef AES_TX_STATS_EN
            A_FRAMES: rd_data_c = frames_q;
            A_STALLS: rd_data_c = stalls_q;
`endif
            default:  rd_data_c = '0;
        endcase
    end

    // Live config registers; a frame only sees them at its SOP
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= '0;
            dst_q      <= '0;
            blocks_q   <= CNT_W'(DEF_BLOCKS);
            readdata_q <= '0;
        end else begin
            if (bus.avs_read)
                readdata_q <= rd_data_c;
            if (bus.avs_write) begin
                case (bus.avs_address)
                    A_SRC_HI: src_q[47:32] <= bus.avs_writedata[15:0];
                    A_SRC_LO: src_q[31:0]  <= bus.avs_writedata;
                    A_DST_HI: dst_q[47:32] <= bus.avs_writedata[15:0];
                    A_DST_LO: dst_q[31:0]  <= bus.avs_writedata;
                    A_BLOCKS: blocks_q     <= bus.avs_writedata[CNT_W-1:0];
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_eth_tx_ctrl.sv
// Directed bench for aes_eth_tx_ctrl: frame contents, back-pressure, shadowing, reset abort, stats.
module tb_aes_eth_tx_ctrl;
    localparam logic [31:0] BASE     = 32'h1000;
    localparam logic [31:0] A_SRC_HI = BASE + 32'h00;
    localparam logic [31:0] A_SRC_LO = BASE + 32'h04;
    localparam logic [31:0] A_DST_HI = BASE + 32'h08;
    localparam logic [31:0] A_DST_LO = BASE + 32'h0C;
    localparam logic [31:0] A_BLOCKS = BASE + 32'h10;
    localparam logic [31:0] A_STATUS = BASE + 32'h14;
    localparam logic [31:0] A_FRAMES = BASE + 32'h18;
    localparam logic [31:0] A_UNMAP  = BASE + 32'h40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    aes_eth_tx_ctrl_if bus ();

    aes_eth_tx_ctrl #(.BASE_ADDR(BASE), .DEF_BLOCKS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          takes    = 0;
    int          rdy_mode = 0;
    bit          abort    = 1'b0;
    bit          bg_done  = 1'b0;
    logic [33:0] rxq[$];
    int          cq[$];
    logic [31:0] exp_q[$];
    logic [31:0] rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mkblk(input logic [7:0] b);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = b + 8'(k);
        return r;
    endfunction

    // tx_ready pattern: 0 steady high, 1 toggling
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) bus.tx_ready = ~bus.tx_ready;
            else               bus.tx_ready = 1'b1;
        end
    end

    // Monitor: log accepted words, count AES takes, verify words hold across stalls
    initial begin
        logic        hold_v;
        logic [33:0] hold_d;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tx_valid && bus.tx_ready) begin
                    rxq.push_back({bus.tx_sop, bus.tx_eop, bus.tx_data});
                    cq.push_back(cyc);
                end
                if (bus.aes_valid && bus.aes_ready) takes++;
                if (hold_v && bus.tx_valid)
                    check("stall_hold", 64'({bus.tx_sop, bus.tx_eop, bus.tx_data}), 64'(hold_d));
                hold_v = bus.tx_valid && !bus.tx_ready;
                hold_d = {bus.tx_sop, bus.tx_eop, bus.tx_data};
            end else begin
                hold_v = 1'b0;
            end
            cyc++;
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic avs_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.avs_address = a; bus.avs_read = 1'b1;
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        @(negedge clk);
        d = bus.avs_readdata;
    endtask

    task automatic avs_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] d);
        @(posedge clk); #1;
        bus.avs_address = a; bus.avs_writedata = wd; bus.avs_write = 1'b1; bus.avs_read = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        @(negedge clk);
        d = bus.avs_readdata;
    endtask

    task automatic send_blocks(input int n, input logic [7:0] seed);
        for (int i = 0; i < n && !abort; i++) begin
            int g;
            g = 0;
            bus.aes_data  = mkblk(8'(seed + 8'(16 * i)));
            bus.aes_valid = 1'b1;
            @(negedge clk);
            while (!bus.aes_ready && !abort && g < 500) begin
                @(negedge clk);
                g++;
            end
            check("aes_take_timeout", 64'(g >= 500), 64'd0);
            @(posedge clk); #1;
        end
        bus.aes_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int g;
        g = 0;
        while (rxq.size() < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("word_wait", 64'(rxq.size() >= n), 64'd1);
    endtask

    task automatic build_exp(input logic [47:0] dst, input logic [47:0] src, input int n,
                             input logic [7:0] seed);
        logic [127:0] b;
        exp_q.delete();
        exp_q.push_back({16'h0000, dst[47:32]});
        exp_q.push_back(dst[31:0]);
        exp_q.push_back(src[47:16]);
        exp_q.push_back({src[15:0], 16'h0800});
        for (int i = 0; i < n; i++) begin
            b = mkblk(8'(seed + 8'(16 * i)));
            for (int w = 0; w < 4; w++) exp_q.push_back(b[127-32*w -: 32]);
        end
    endtask

    // Compare the captured frame with exp_q, then clear the capture
    task automatic check_frame(input string tag);
        int n;
        n = exp_q.size();
        wait_words(n);
        repeat (4) @(negedge clk);
        check({tag, "_len"}, 64'(rxq.size()), 64'(n));
        for (int i = 0; i < n && i < rxq.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(rxq[i]),
                  64'({(i == 0), (i == n - 1), exp_q[i]}));
        rxq.delete();
        cq.delete();
    endtask

    initial begin
        bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
        bus.aes_data = '0; bus.aes_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_aes_ready", 64'(bus.aes_ready), 64'd0);
        check("rst_readdata", 64'(bus.avs_readdata), 64'd0);
        check("rst_tx_empty", 64'(bus.tx_empty), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        avs_rd(A_BLOCKS, rd);  check("blocks_default", 64'(rd), 64'd1);
        avs_rw(A_BLOCKS, 32'h7, rd); check("rw_old_value", 64'(rd), 64'd1);
        avs_rd(A_BLOCKS, rd);  check("blocks_new", 64'(rd), 64'd7);
        avs_wr(A_BLOCKS, 32'h1FF);
        avs_rd(A_BLOCKS, rd);  check("blocks_8bit", 64'(rd), 64'hFF);
        avs_wr(A_STATUS, 32'h1);
        avs_rd(A_STATUS, rd);  check("status_ro", 64'(rd), 64'd0);
        avs_rd(A_UNMAP, rd);   check("unmapped_rd", 64'(rd), 64'd0);

        // Test 1: single-block frame
        avs_wr(A_SRC_HI, 32'h0011);
        avs_wr(A_SRC_LO, 32'h22334455);
        avs_wr(A_DST_HI, 32'hAABB);
        avs_wr(A_DST_LO, 32'hCCDDEEFF);
        avs_wr(A_BLOCKS, 32'h1);
        avs_rd(A_SRC_HI, rd);  check("src_hi_rb", 64'(rd), 64'h0011);
        exp_q = '{32'h0000AABB, 32'hCCDDEEFF, 32'h00112233, 32'h44550800,
                  32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        send_blocks(1, 8'h00);
        check_frame("t1");

        // Test 2: three blocks at full rate
        avs_wr(A_BLOCKS, 32'h3);
        takes = 0;
        send_blocks(3, 8'h20);
        wait_words(16);
        check("t2_span", 64'(cq[15] - cq[0]), 64'd15);
        check("t2_takes", 64'(takes), 64'd3);
        build_exp(48'hAABB_CCDDEEFF, 48'h0011_22334455, 3, 8'h20);
        check_frame("t2");

        // Test 3: same frame under alternating back-pressure
        rdy_mode = 1;
        takes = 0;
        send_blocks(3, 8'h20);
        build_exp(48'hAABB_CCDDEEFF, 48'h0011_22334455, 3, 8'h20);
        check_frame("t3");
        check("t3_takes", 64'(takes), 64'd3);
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Test 4: DST rewritten while the header is in flight
        avs_wr(A_BLOCKS, 32'h1);
        fork
            send_blocks(1, 8'h40);
            begin
                repeat (2) @(posedge clk);
                #1;
                avs_wr(A_DST_HI, 32'h0);
                avs_wr(A_DST_LO, 32'h1);
            end
        join
        build_exp(48'hAABB_CCDDEEFF, 48'h0011_22334455, 1, 8'h40);
        check_frame("t4a");
        send_blocks(1, 8'h50);
        build_exp(48'h0000_00000001, 48'h0011_22334455, 1, 8'h50);
        check_frame("t4b");

        // Test 5: reset in the middle of the payload
        avs_wr(A_BLOCKS, 32'h3);
        abort = 1'b0; bg_done = 1'b0;
        fork
            begin
                send_blocks(3, 8'h60);
                bg_done = 1'b1;
            end
        join_none
        wait_words(5);
        @(posedge clk); #1;
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_aes_ready", 64'(bus.aes_ready), 64'd0);
        begin
            int g;
            g = 0;
            while (!bg_done && g < 100) begin
                @(negedge clk);
                g++;
            end
        end
        check("t5_bg_done", 64'(bg_done), 64'd1);
        bus.aes_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        abort = 1'b0;
        rxq.delete();
        cq.delete();
        avs_rd(A_SRC_HI, rd);  check("t5_src_hi", 64'(rd), 64'd0);
        avs_rd(A_SRC_LO, rd);  check("t5_src_lo", 64'(rd), 64'd0);
        avs_rd(A_DST_HI, rd);  check("t5_dst_hi", 64'(rd), 64'd0);
        avs_rd(A_DST_LO, rd);  check("t5_dst_lo", 64'(rd), 64'd0);
        avs_rd(A_BLOCKS, rd);  check("t5_blocks", 64'(rd), 64'd1);
        avs_rd(A_STATUS, rd);  check("t5_status", 64'(rd), 64'd0);
        check("t5_no_words", 64'(rxq.size()), 64'd0);

        // Test 6: BLOCKS=0 sends one block; stats counters
        avs_wr(A_BLOCKS, 32'h0);
        avs_rd(A_BLOCKS, rd);  check("t6_blocks_rb", 64'(rd), 64'd0);
        send_blocks(1, 8'h70);
        build_exp(48'h0, 48'h0, 1, 8'h70);
        check_frame("t6a");
        send_blocks(1, 8'h80);
        build_exp(48'h0, 48'h0, 1, 8'h80);
        check_frame("t6b");
        avs_rd(A_FRAMES, rd);
`ifdef AES_TX_STATS_EN
        check("t6_frames", 64'(rd), 64'd2);
`else
        check("t6_frames", 64'(rd), 64'd0);
`endif
        avs_wr(A_FRAMES, 32'h5A);
        avs_rd(A_FRAMES, rd);  check("t6_frames_clr", 64'(rd), 64'd0);
        avs_rd(A_STATUS, rd);  check("t6_status", 64'(rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
